// File: rtl/snake_pkg.sv
// Shared types and constants for the snake position tracker: screen geometry,
// direction and FSM encodings, and direction helpers.
package snake_pkg;

  localparam int SEG      = 20;
  localparam int MAX_LEN  = 20;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // Buttons are {up,down,left,right}; the highest pressed wins.
  function automatic dir_t btn_to_dir(input logic [3:0] btn);
    if (btn[3])      return UP;
    else if (btn[2]) return DOWN;
    else if (btn[1]) return LEFT;
    else             return RIGHT;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick divider: counts vga_clk cycles while enabled and pulses tick on the
// last count of each TICK_DIV-cycle period.
module snake_tick_gen #(
  parameter int TICK_DIV = 2500000
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge vga_clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake head position, direction latch, growth and body-segment history.
// Outputs are a stable frame between move ticks for the collision checker.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int SEG      = snake_pkg::SEG,
  parameter int MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int START_X  = 320,
  parameter int START_Y  = 240,
  parameter int TICK_DIV = 2500000
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [3:0]            btn_dir,
  input  logic                  grow,
  input  logic                  game_over,
  output logic [9:0]            snakex,
  output logic [9:0]            snakey,
  output logic [MAX_LEN*10-1:0] storex,
  output logic [MAX_LEN*10-1:0] storey,
  output logic [7:0]            length,
  output logic                  move_tick
);

  state_t      state;
  dir_t        dir;
  dir_t        req;
  logic        dir_locked;
  logic        grow_pend;
  logic        active;
  logic        accept;
  logic        tick;
  logic [10:0] nx;
  logic [10:0] ny;

  assign active = (state == RUN) && !game_over;
  assign req    = btn_to_dir(btn_dir);
  // Only a real turn locks the direction; re-pressing the current way is a no-op.
  assign accept = active && (|btn_dir) && !dir_locked && (req != dir) && (req != opposite(dir));

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (active),
    .clr     (state == IDLE),
    .tick    (tick)
  );

  // NOTE: both next-head values get a default before the case so no path
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    nx = {1'b0, snakex};
    ny = {1'b0, snakey};
    case (dir)
      RIGHT: begin
        nx = {1'b0, snakex} + 11'(SEG);
        if (nx >= 11'(SCREEN_W)) nx = nx - 11'(SCREEN_W);
      end
      LEFT: begin
        if ({1'b0, snakex} < 11'(SEG)) nx = {1'b0, snakex} + 11'(SCREEN_W) - 11'(SEG);
        else                           nx = {1'b0, snakex} - 11'(SEG);
      end
      DOWN: begin
        ny = {1'b0, snakey} + 11'(SEG);
        if (ny >= 11'(SCREEN_H)) ny = ny - 11'(SCREEN_H);
      end
      UP: begin
        if ({1'b0, snakey} < 11'(SEG)) ny = {1'b0, snakey} + 11'(SCREEN_H) - 11'(SEG);
        else                           ny = {1'b0, snakey} - 11'(SEG);
      end
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= RIGHT;
      dir_locked <= 1'b0;
      grow_pend  <= 1'b0;
      snakex     <= 10'(START_X);
      snakey     <= 10'(START_Y);
      length     <= '0;
      move_tick  <= 1'b0;
    end else begin
      move_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (|btn_dir) begin
            state      <= RUN;
            dir        <= req;
            dir_locked <= 1'b0;
          end
        end
        RUN: begin
          if (game_over) begin
            state <= DEAD;
          end else begin
            if (grow)   grow_pend <= 1'b1;
            if (accept) dir <= req;
            if (tick) begin
              move_tick  <= 1'b1;
              snakex     <= nx[9:0];
              snakey     <= ny[9:0];
              grow_pend  <= 1'b0;
              // A turn taken on the tick cycle belongs to the next interval.
              dir_locked <= accept;
              if ((grow_pend || grow) && (length < 8'(MAX_LEN))) length <= length + 8'd1;
            end else if (accept) begin
              dir_locked <= 1'b1;
            end
          end
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

  logic [9:0] body_x [MAX_LEN];
  logic [9:0] body_y [MAX_LEN];

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
    logic [9:0] src_x;
    logic [9:0] src_y;
    if (i == 0) begin : g_head
      assign src_x = snakex;
      assign src_y = snakey;
    end else begin : g_prev
      assign src_x = body_x[i-1];
      assign src_y = body_y[i-1];
    end

    // NOTE: body slots are read by the checker every pixel, so unlike a RAM
    // they need a defined reset value.
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        body_x[i] <= '0;
        body_y[i] <= '0;
      end else if (tick) begin
        body_x[i] <= src_x;
        body_y[i] <= src_y;
      end
    end

    assign storex[i*10 +: 10] = body_x[i];
    assign storey[i*10 +: 10] = body_y[i];
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with TICK_DIV=4: movement, growth,
// reversal and lock rules, screen wrap, saturation, freeze and reset.
module tb_snake_body_tracker;

  localparam int MAX_LEN = 20;

  logic                  vga_clk = 1'b0;
  logic                  reset;
  logic [3:0]            btn_dir;
  logic                  grow;
  logic                  game_over;
  logic [9:0]            snakex;
  logic [9:0]            snakey;
  logic [MAX_LEN*10-1:0] storex;
  logic [MAX_LEN*10-1:0] storey;
  logic [7:0]            length;
  logic                  move_tick;

  int checks   = 0;
  int failures = 0;

  snake_body_tracker #(.TICK_DIV(4)) dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .grow      (grow),
    .game_over (game_over),
    .snakex    (snakex),
    .snakey    (snakey),
    .storex    (storex),
    .storey    (storey),
    .length    (length),
    .move_tick (move_tick)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic cycle();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cycle();
      seen = move_tick;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: move_tick got 0 within 20 cycles, wanted 1", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_dir = 4'b0000; grow = 1'b0; game_over = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    checks++;
    if (snakex !== 10'd320 || snakey !== 10'd240) begin
      failures++; $display("FAIL reset_head: got (%0d,%0d) wanted (320,240)", snakex, snakey);
    end
    checks++;
    if (length !== 8'd0 || move_tick !== 1'b0) begin
      failures++; $display("FAIL reset_len_tick: got len=%0d tick=%b wanted 0/0", length, move_tick);
    end
    checks++;
    if (storex !== '0 || storey !== '0) begin
      failures++; $display("FAIL reset_store: body store not zero");
    end
  endtask

  task automatic test_first_move();
    int n = 0;
    btn_dir = 4'b0001;
    cycle();
    btn_dir = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      cycle(); n++;
      if (move_tick) break;
    end
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL first_tick_latency: got %0d cycles wanted 4", n);
    end
    checks++;
    if (snakex !== 10'd340 || snakey !== 10'd240) begin
      failures++; $display("FAIL first_move_head: got (%0d,%0d) wanted (340,240)", snakex, snakey);
    end
    checks++;
    if (storex[0 +: 10] !== 10'd320 || storey[0 +: 10] !== 10'd240 || length !== 8'd0) begin
      failures++;
      $display("FAIL first_move_body: got slot0=(%0d,%0d) len=%0d wanted (320,240) 0",
               storex[0 +: 10], storey[0 +: 10], length);
    end
    cycle();
    checks++;
    if (move_tick !== 1'b0 || snakex !== 10'd340) begin
      failures++; $display("FAIL tick_pulse_width: got tick=%b x=%0d wanted 0 340", move_tick, snakex);
    end
  endtask

  task automatic test_grow();
    grow = 1'b1; cycle(); grow = 1'b0;
    wait_tick("grow_t1");
    checks++;
    if (length !== 8'd1 || snakex !== 10'd360) begin
      failures++; $display("FAIL grow_first: got len=%0d x=%0d wanted 1 360", length, snakex);
    end
    wait_tick("grow_t2");
    checks++;
    if (snakex !== 10'd380 || length !== 8'd1) begin
      failures++; $display("FAIL grow_second: got x=%0d len=%0d wanted 380 1", snakex, length);
    end
    checks++;
    if (storex[0 +: 10] !== 10'd360 || storex[10 +: 10] !== 10'd340 || storex[20 +: 10] !== 10'd320 ||
        storey[0 +: 10] !== 10'd240 || storey[10 +: 10] !== 10'd240 || storey[20 +: 10] !== 10'd240) begin
      failures++;
      $display("FAIL body_shift: got x=%0d,%0d,%0d y=%0d,%0d,%0d wanted 360,340,320 240,240,240",
               storex[0 +: 10], storex[10 +: 10], storex[20 +: 10],
               storey[0 +: 10], storey[10 +: 10], storey[20 +: 10]);
    end
  endtask

  task automatic test_no_reverse();
    btn_dir = 4'b0010; cycle(); btn_dir = 4'b0000;
    wait_tick("no_reverse");
    checks++;
    if (snakex !== 10'd400 || snakey !== 10'd240) begin
      failures++; $display("FAIL no_reverse: got (%0d,%0d) wanted (400,240)", snakex, snakey);
    end
  endtask

  task automatic test_dir_lock();
    btn_dir = 4'b1000; cycle();
    btn_dir = 4'b0100; cycle();
    btn_dir = 4'b0010; cycle();
    btn_dir = 4'b0000;
    wait_tick("dir_lock");
    checks++;
    if (snakex !== 10'd400 || snakey !== 10'd220) begin
      failures++; $display("FAIL dir_lock: got (%0d,%0d) wanted (400,220)", snakex, snakey);
    end
  endtask

  task automatic test_wrap_x();
    btn_dir = 4'b0010; cycle(); btn_dir = 4'b0000;
    for (int i = 1; i <= 21; i++) begin
      wait_tick("wrap_x");
      if (i == 20) begin
        checks++;
        if (snakex !== 10'd0) begin
          failures++; $display("FAIL wrap_x_edge: got x=%0d wanted 0", snakex);
        end
      end
    end
    checks++;
    if (snakex !== 10'd620 || snakey !== 10'd220) begin
      failures++; $display("FAIL wrap_x: got (%0d,%0d) wanted (620,220)", snakex, snakey);
    end
  endtask

  task automatic test_wrap_y();
    btn_dir = 4'b0100; cycle(); btn_dir = 4'b0000;
    for (int i = 1; i <= 13; i++) begin
      wait_tick("wrap_y");
      if (i == 12) begin
        checks++;
        if (snakey !== 10'd460) begin
          failures++; $display("FAIL wrap_y_edge: got y=%0d wanted 460", snakey);
        end
      end
    end
    checks++;
    if (snakey !== 10'd0 || snakex !== 10'd620) begin
      failures++; $display("FAIL wrap_y: got (%0d,%0d) wanted (620,0)", snakex, snakey);
    end
  endtask

  task automatic test_saturate();
    int exp_len = 1;
    // Pulse lands on the tick cycle itself.
    repeat (3) cycle();
    grow = 1'b1; cycle(); grow = 1'b0;
    exp_len = 2;
    checks++;
    if (move_tick !== 1'b1 || length !== 8'(exp_len)) begin
      failures++; $display("FAIL grow_on_tick: got tick=%b len=%0d wanted 1 %0d", move_tick, length, exp_len);
    end
    // Two pulses in one interval count once.
    grow = 1'b1; cycle(); grow = 1'b0; cycle();
    grow = 1'b1; cycle(); grow = 1'b0;
    wait_tick("grow_double");
    exp_len = 3;
    checks++;
    if (length !== 8'(exp_len)) begin
      failures++; $display("FAIL grow_double: got len=%0d wanted %0d", length, exp_len);
    end
    for (int i = 2; i < 25; i++) begin
      grow = 1'b1; cycle(); grow = 1'b0;
      wait_tick("saturate");
      exp_len = (exp_len < MAX_LEN) ? exp_len + 1 : MAX_LEN;
      checks++;
      if (length !== 8'(exp_len)) begin
        failures++; $display("FAIL saturate_%0d: got len=%0d wanted %0d", i, length, exp_len);
      end
    end
  endtask

  task automatic test_game_over();
    repeat (3) cycle();
    game_over = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c == 50) begin
        game_over = 1'b0; btn_dir = 4'b1000; grow = 1'b1;
      end
      cycle();
      checks++;
      if (move_tick !== 1'b0 || snakex !== 10'd620 || snakey !== 10'd20 || length !== 8'd20 ||
          storex[0 +: 10] !== 10'd620 || storey[0 +: 10] !== 10'd0) begin
        failures++;
        $display("FAIL frozen_%0d: got tick=%b head=(%0d,%0d) len=%0d slot0=(%0d,%0d) wanted 0 (620,20) 20 (620,0)",
                 c, move_tick, snakex, snakey, length, storex[0 +: 10], storey[0 +: 10]);
      end
    end
    btn_dir = 4'b0000; grow = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    checks++;
    if (snakex !== 10'd320 || snakey !== 10'd240 || length !== 8'd0 || storex !== '0 || move_tick !== 1'b0) begin
      failures++;
      $display("FAIL dead_reset: got head=(%0d,%0d) len=%0d tick=%b wanted (320,240) 0 0",
               snakex, snakey, length, move_tick);
    end
  endtask

  task automatic test_idle_and_reset_grow();
    bit any_tick = 1'b0;
    grow = 1'b1; cycle(); grow = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (move_tick) any_tick = 1'b1;
    end
    checks++;
    if (any_tick || snakex !== 10'd320) begin
      failures++; $display("FAIL idle_hold: got tick_seen=%b x=%0d wanted 0 320", any_tick, snakex);
    end
    btn_dir = 4'b0001; cycle(); btn_dir = 4'b0000;
    wait_tick("idle_grow");
    checks++;
    if (length !== 8'd0 || snakex !== 10'd340) begin
      failures++; $display("FAIL idle_grow_ignored: got len=%0d x=%0d wanted 0 340", length, snakex);
    end
    grow = 1'b1; cycle(); grow = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    checks++;
    if (snakex !== 10'd320 || storex !== '0) begin
      failures++; $display("FAIL mid_reset: got x=%0d wanted 320 and empty body", snakex);
    end
    btn_dir = 4'b0001; cycle(); btn_dir = 4'b0000;
    wait_tick("reset_grow");
    checks++;
    if (length !== 8'd0 || snakex !== 10'd340) begin
      failures++; $display("FAIL pending_grow_lost: got len=%0d x=%0d wanted 0 340", length, snakex);
    end
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_first_move();
    test_grow();
    test_no_reverse();
    test_dir_lock();
    test_wrap_x();
    test_wrap_y();
    test_saturate();
    test_game_over();
    test_idle_and_reset_grow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
